// File: rtl/glyph_frame_sequencer.sv
// glyph_frame_sequencer: single-clock frame-rate controller for glyph-rain VGA.
// Detects vsync edges, counts frames, and sequences palette fade transitions.
module glyph_frame_sequencer #(
    parameter int FRAME_W      = 10,
    parameter int FADE_FRAMES  = 4,
    parameter int VSYNC_ACTIVE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               pause,
    input  logic [1:0]         pal_req,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_tick,
    output logic               intro_done,
    output logic [1:0]         pal_sel,
    output logic [1:0]         fade,
    output logic               busy
);

    localparam logic       ACT  = (VSYNC_ACTIVE != 0);
    localparam logic [3:0] TMAX = 4'(FADE_FRAMES - 1);

    typedef enum logic [1:0] {
        RUN,
        FADE_OUT,
        SWAP,
        FADE_IN
    } state_t;

    state_t               r_state;
    logic [3:0]           r_timer;
    logic                 r_vsync_q;
    logic                 r_armed;
    logic [FRAME_W-1:0]   r_frame;
    logic                 r_frame_tick;
    logic                 r_intro_done;
    logic [1:0]           r_pal_sel;
    logic [1:0]           r_fade;
    logic                 r_busy;
    logic                 w_tick;

    // r_armed blocks a tick when vsync is already active at reset release
    assign w_tick = r_armed && (vsync == ACT) && (r_vsync_q != ACT);

    // Delay vsync one cycle and arm edge detection once vsync is seen inactive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vsync_q <= ~ACT;
            r_armed   <= 1'b0;
        end else begin
            r_vsync_q <= vsync;
            if (vsync != ACT) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Frame counter, frame pulse and sticky intro flag, all updated on tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame      <= '0;
            r_frame_tick <= 1'b0;
            r_intro_done <= 1'b0;
        end else begin
            r_frame_tick <= w_tick;
            if (w_tick && !pause) begin
                r_frame <= r_frame + FRAME_W'(1);
                if (&r_frame) begin
                    r_intro_done <= 1'b1;
                end
            end
        end
    end

    // Palette transition FSM: fade out, swap palette, fade in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RUN;
            r_timer   <= 4'd0;
            r_pal_sel <= 2'd0;
            r_fade    <= 2'd3;
            r_busy    <= 1'b0;
        end else if (w_tick) begin
            unique case (r_state)
                RUN: begin
                    if (pal_req != r_pal_sel) begin
                        r_state <= FADE_OUT;
                        r_timer <= 4'd0;
                        r_fade  <= 2'd3;
                        r_busy  <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    if (r_timer == TMAX) begin
                        r_timer <= 4'd0;
                        if (r_fade == 2'd0) begin
                            r_state <= SWAP;
                        end else begin
                            r_fade <= r_fade - 2'd1;
                        end
                    end else begin
                        r_timer <= r_timer + 4'd1;
                    end
                end
                SWAP: begin
                    r_pal_sel <= pal_req;
                    r_timer   <= 4'd0;
                    r_state   <= FADE_IN;
                end
                FADE_IN: begin
                    if (r_timer == TMAX) begin
                        r_timer <= 4'd0;
                        if (r_fade == 2'd3) begin
                            r_state <= RUN;
                            r_busy  <= 1'b0;
                        end else begin
                            r_fade <= r_fade + 2'd1;
                        end
                    end else begin
                        r_timer <= r_timer + 4'd1;
                    end
                end
            endcase
        end
    end

    assign frame      = r_frame;
    assign frame_tick = r_frame_tick;
    assign intro_done = r_intro_done;
    assign pal_sel    = r_pal_sel;
    assign fade       = r_fade;
    assign busy       = r_busy;

endmodule

// File: tb/tb_glyph_frame_sequencer.sv
// tb_glyph_frame_sequencer: directed bench for glyph_frame_sequencer.
// Expected values are hand-derived from the fade timing of FADE_FRAMES=4.
module tb_glyph_frame_sequencer;

    localparam logic ACT = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       pause;
    logic [1:0] pal_req;
    logic [9:0] frame;
    logic       frame_tick;
    logic       intro_done;
    logic [1:0] pal_sel;
    logic [1:0] fade;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int tick_cnt = 0;
    int f34;
    int tc34;
    int tc0;

    glyph_frame_sequencer #(
        .FRAME_W(10),
        .FADE_FRAMES(4),
        .VSYNC_ACTIVE(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vsync(vsync),
        .pause(pause),
        .pal_req(pal_req),
        .frame(frame),
        .frame_tick(frame_tick),
        .intro_done(intro_done),
        .pal_sel(pal_sel),
        .fade(fade),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_tick) tick_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic vpulse();
        @(negedge clk) vsync = ACT;
        @(negedge clk) vsync = ~ACT;
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".frame"}, int'(frame), 0);
        chk({tag, ".tick"}, int'(frame_tick), 0);
        chk({tag, ".intro"}, int'(intro_done), 0);
        chk({tag, ".pal_sel"}, int'(pal_sel), 0);
        chk({tag, ".fade"}, int'(fade), 3);
        chk({tag, ".busy"}, int'(busy), 0);
    endtask

    initial begin
        reset   = 1'b1;
        vsync   = ~ACT;
        pause   = 1'b0;
        pal_req = 2'd0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;

        // three frames
        repeat (3) vpulse();
        chk("f3.frame", int'(frame), 3);
        chk("f3.ticks", tick_cnt, 3);
        chk("f3.fade", int'(fade), 3);
        chk("f3.pal_sel", int'(pal_sel), 0);
        chk("f3.busy", int'(busy), 0);
        chk("f3.intro", int'(intro_done), 0);

        // run up to the wrap
        repeat (1020) vpulse();
        chk("pre.frame", int'(frame), 1023);
        chk("pre.intro", int'(intro_done), 0);
        vpulse();
        chk("wrap.frame", int'(frame), 0);
        chk("wrap.intro", int'(intro_done), 1);
        repeat (1100) vpulse();
        chk("post.frame", int'(frame), 76);
        chk("post.intro", int'(intro_done), 1);
        chk("post.ticks", tick_cnt, 2124);

        // plain transition 0 -> 2
        pal_req = 2'd2;
        vpulse();
        chk("t0.fade", int'(fade), 3);
        chk("t0.busy", int'(busy), 1);
        for (int k = 1; k <= 33; k++) begin
            vpulse();
            if (k == 4)  chk("a4.fade", int'(fade), 2);
            if (k == 8)  chk("a8.fade", int'(fade), 1);
            if (k == 12) chk("a12.fade", int'(fade), 0);
            if (k == 16) chk("a16.pal", int'(pal_sel), 0);
            if (k == 17) chk("a17.pal", int'(pal_sel), 2);
            if (k == 21) chk("a21.fade", int'(fade), 1);
            if (k == 25) chk("a25.fade", int'(fade), 2);
            if (k == 29) chk("a29.fade", int'(fade), 3);
            if (k == 32) chk("a32.busy", int'(busy), 1);
            if (k == 33) chk("a33.busy", int'(busy), 0);
        end

        // absorbed change, FADE_IN request, pause during next fade
        pal_req = 2'd3;
        vpulse();
        chk("b0.busy", int'(busy), 1);
        f34  = 0;
        tc34 = 0;
        for (int k = 1; k <= 67; k++) begin
            if (k == 6)  pal_req = 2'd1;
            if (k == 20) pal_req = 2'd0;
            if (k == 35) pause = 1'b1;
            if (k == 45) pause = 1'b0;
            vpulse();
            if (k == 16) chk("b16.pal", int'(pal_sel), 2);
            if (k == 17) chk("b17.pal", int'(pal_sel), 1);
            if (k == 33) chk("b33.busy", int'(busy), 0);
            if (k == 33) chk("b33.fade", int'(fade), 3);
            if (k == 34) begin
                chk("b34.busy", int'(busy), 1);
                f34  = int'(frame);
                tc34 = tick_cnt;
            end
            if (k == 38) chk("b38.fade", int'(fade), 2);
            if (k == 44) begin
                chk("b44.frame", int'(frame), f34);
                chk("b44.ticks", tick_cnt - tc34, 10);
                chk("b44.fade", int'(fade), 1);
            end
            if (k == 45) chk("b45.frame", int'(frame), (f34 + 1) % 1024);
            if (k == 51) chk("b51.pal", int'(pal_sel), 0);
            if (k == 67) chk("b67.busy", int'(busy), 0);
        end

        // reset in FADE_IN with fade=1, pal_sel=2
        pal_req = 2'd2;
        vpulse();
        repeat (21) vpulse();
        chk("c21.fade", int'(fade), 1);
        chk("c21.pal", int'(pal_sel), 2);
        chk("c21.busy", int'(busy), 1);
        @(negedge clk);
        pal_req = 2'd0;
        reset   = 1'b1;
        vsync   = ACT;
        #1;
        check_reset_state("mid");
        @(negedge clk);
        reset = 1'b0;

        // vsync active at release: no tick
        tc0 = tick_cnt;
        repeat (20) @(negedge clk);
        chk("hold.ticks", tick_cnt - tc0, 0);
        chk("hold.frame", int'(frame), 0);

        // long active vsync: one tick
        vsync = ~ACT;
        repeat (2) @(negedge clk);
        vsync = ACT;
        repeat (500) @(negedge clk);
        vsync = ~ACT;
        repeat (2) @(negedge clk);
        chk("long.ticks", tick_cnt - tc0, 1);
        chk("long.frame", int'(frame), 1);
        chk("long.busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
